dispatch_stage: RTL and testbench

DISPATCH_STAGE -- requirements
Module: dispatch_stage

---
 rtl/dispatch_stage.sv | 144 ++++++++++++++
 tb/tb_dispatch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
// Dispatch stage: resolves source operands against a register scoreboard with
// writeback bypass, assigns ROB IDs and issues one instruction per cycle.
module dispatch_stage #(
   parameter int unsigned REG_ADDRESS_SIZE = 5,
   parameter int unsigned REG_SIZE         = 32,
   parameter int unsigned ID_SIZE          = 3,
   parameter int unsigned NUM_FU           = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [REG_ADDRESS_SIZE-1:0] in_r1,
   input  logic [REG_ADDRESS_SIZE-1:0] in_r2,
   input  logic                        in_ie,
   input  logic [REG_SIZE-1:0]         in_immediate,
   input  logic [REG_ADDRESS_SIZE-1:0] in_dest,
   input  logic                        in_we,
   input  logic [NUM_FU-1:0]           in_fu,
   input  logic [REG_SIZE-1:0]         rf_data1,
   input  logic [REG_SIZE-1:0]         rf_data2,
   input  logic                        wb_valid,
   input  logic [ID_SIZE-1:0]          wb_id,
   input  logic [REG_SIZE-1:0]         wb_value,
   input  logic [NUM_FU-1:0]           fu_stall,
   input  logic                        rob_stall,
   input  logic                        flush,
   input  logic [ID_SIZE-1:0]          flush_tail,
   output logic                        out_valid,
   output logic [REG_SIZE-1:0]         out_operand1,
   output logic [REG_SIZE-1:0]         out_operand2,
   output logic [REG_ADDRESS_SIZE-1:0] out_dest,
   output logic                        out_we,
   output logic [NUM_FU-1:0]           out_fu,
   output logic [ID_SIZE-1:0]          out_id,
   output logic                        stall,
   output logic [ID_SIZE-1:0]          tail
);

   localparam int unsigned NUM_REGS = 1 << REG_ADDRESS_SIZE;

   logic [NUM_REGS-1:0] r_pending;
   logic [ID_SIZE-1:0]  r_producer [NUM_REGS];

   logic [NUM_REGS-1:0] w_pending_nxt;
   logic                w_pend1;
   logic                w_pend2;
   logic                w_haz1;
   logic                w_haz2;
   logic [REG_SIZE-1:0] w_opnd1;
   logic [REG_SIZE-1:0] w_opnd2;
   logic                w_fu_onehot;
   logic                w_fu_busy;
   logic                w_fire;
   logic                w_set;

   // Operand resolution: a pending source is usable only if its producer writes back now
   always_comb begin
      w_pend1 = r_pending[in_r1];
      w_pend2 = r_pending[in_r2] & ~in_ie;
      w_haz1  = w_pend1 & ~(wb_valid & (wb_id == r_producer[in_r1]));
      w_haz2  = w_pend2 & ~(wb_valid & (wb_id == r_producer[in_r2]));
      w_opnd1 = w_pend1 ? wb_value : rf_data1;
      if (in_ie) begin
         w_opnd2 = in_immediate;
      end else begin
         w_opnd2 = w_pend2 ? wb_value : rf_data2;
      end
   end

   always_comb begin
      w_fu_onehot = (in_fu != '0) && ((in_fu & (in_fu - NUM_FU'(1))) == '0);
      w_fu_busy   = |(in_fu & fu_stall);
      stall       = in_valid & (rob_stall | w_fu_busy | w_haz1 | w_haz2 | ~w_fu_onehot);
      w_fire      = in_valid & ~stall & ~flush;
      w_set       = w_fire & in_we & (in_dest != '0);
   end

   // Scoreboard next state: writeback clears, a new producer set wins, flush wipes all
   always_comb begin
      w_pending_nxt = r_pending;
      if (wb_valid) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_producer[i] == wb_id) begin
               w_pending_nxt[i] = 1'b0;
            end
         end
      end
      if (w_set) begin
         w_pending_nxt[in_dest] = 1'b1;
      end
      if (flush) begin
         w_pending_nxt = '0;
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   // Producer IDs are only meaningful while the pending bit is set
   always_ff @(posedge clk) begin
      if (w_set) begin
         r_producer[in_dest] <= tail;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tail <= '0;
      end else if (flush) begin
         tail <= flush_tail;
      end else if (w_fire) begin
         tail <= tail + ID_SIZE'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_operand1 <= '0;
         out_operand2 <= '0;
         out_dest     <= '0;
         out_we       <= 1'b0;
         out_fu       <= '0;
         out_id       <= '0;
      end else begin
         out_valid <= w_fire;
         if (w_fire) begin
            out_operand1 <= w_opnd1;
            out_operand2 <= w_opnd2;
            out_dest     <= in_dest;
            out_we       <= in_we;
            out_fu       <= in_fu;
            out_id       <= tail;
         end
      end
   end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage: operand bypass, hazards,
// ROB ID wrap, flush and asynchronous reset.
module tb_dispatch_stage;

   localparam int unsigned RA = 5;
   localparam int unsigned RS = 32;
   localparam int unsigned IS = 3;
   localparam int unsigned NF = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [RA-1:0] in_r1, in_r2, in_dest;
   logic          in_ie, in_we;
   logic [RS-1:0] in_immediate, rf_data1, rf_data2, wb_value;
   logic [NF-1:0] in_fu, fu_stall;
   logic          wb_valid, rob_stall, flush;
   logic [IS-1:0] wb_id, flush_tail;
   logic          out_valid, out_we, stall;
   logic [RS-1:0] out_operand1, out_operand2;
   logic [RA-1:0] out_dest;
   logic [NF-1:0] out_fu;
   logic [IS-1:0] out_id, tail;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dispatch_stage #(
      .REG_ADDRESS_SIZE(RA), .REG_SIZE(RS), .ID_SIZE(IS), .NUM_FU(NF)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_r1(in_r1), .in_r2(in_r2),
      .in_ie(in_ie), .in_immediate(in_immediate), .in_dest(in_dest), .in_we(in_we),
      .in_fu(in_fu), .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_valid(wb_valid),
      .wb_id(wb_id), .wb_value(wb_value), .fu_stall(fu_stall), .rob_stall(rob_stall),
      .flush(flush), .flush_tail(flush_tail), .out_valid(out_valid),
      .out_operand1(out_operand1), .out_operand2(out_operand2), .out_dest(out_dest),
      .out_we(out_we), .out_fu(out_fu), .out_id(out_id), .stall(stall), .tail(tail)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stall(input string tag, input logic exp);
      #1;
      chk(tag, 32'(stall), 32'(exp));
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_op1"},   out_operand1,   32'd0);
      chk({tag, "_op2"},   out_operand2,   32'd0);
      chk({tag, "_dest"},  32'(out_dest),  32'd0);
      chk({tag, "_we"},    32'(out_we),    32'd0);
      chk({tag, "_fu"},    32'(out_fu),    32'd0);
      chk({tag, "_id"},    32'(out_id),    32'd0);
      chk({tag, "_tail"},  32'(tail),      32'd0);
   endtask

   initial begin
      reset = 1'b0;
      in_valid = 1'b0; in_r1 = '0; in_r2 = '0; in_dest = '0; in_ie = 1'b0; in_we = 1'b0;
      in_immediate = '0; rf_data1 = '0; rf_data2 = '0; wb_value = '0; in_fu = 2'b01;
      fu_stall = '0; wb_valid = 1'b0; rob_stall = 1'b0; flush = 1'b0; wb_id = '0;
      flush_tail = '0;
      #12;
      chk_zero_outputs("reset");
      @(negedge clk);
      reset = 1'b1;

      // First instruction after reset: immediate operand, ID 0
      in_valid = 1'b1; in_r1 = 5'd3; rf_data1 = 32'd7; in_ie = 1'b1; in_immediate = 32'd9;
      in_fu = 2'b01;
      chk_stall("first_stall", 1'b0);
      tick();
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_op1", out_operand1, 32'd7);
      chk("first_op2", out_operand2, 32'd9);
      chk("first_id", 32'(out_id), 32'd0);
      chk("first_tail", 32'(tail), 32'd1);

      in_valid = 1'b0;
      tick();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_op1_hold", out_operand1, 32'd7);
      chk("idle_tail", 32'(tail), 32'd1);

      // Producer of r5 gets ID 1
      in_valid = 1'b1; in_r1 = 5'd0; in_dest = 5'd5; in_we = 1'b1; in_immediate = 32'd0;
      tick();
      chk("prod5_id", 32'(out_id), 32'd1);
      chk("prod5_dest", 32'(out_dest), 32'd5);
      chk("prod5_we", 32'(out_we), 32'd1);
      chk("prod5_tail", 32'(tail), 32'd2);

      // RAW hazard on r5, resolved by matching writeback bypass
      in_we = 1'b0; in_dest = 5'd0; in_r1 = 5'd5; rf_data1 = 32'h1234;
      chk_stall("raw_stall", 1'b1);
      tick();
      chk("raw_valid", 32'(out_valid), 32'd0);
      chk("raw_tail", 32'(tail), 32'd2);
      wb_valid = 1'b1; wb_id = 3'd3; wb_value = 32'h77;
      chk_stall("raw_wrong_wb", 1'b1);
      wb_id = 3'd1; wb_value = 32'h55;
      chk_stall("raw_bypass_stall", 1'b0);
      tick();
      chk("bypass_valid", 32'(out_valid), 32'd1);
      chk("bypass_op1", out_operand1, 32'h55);
      chk("bypass_id", 32'(out_id), 32'd2);
      wb_valid = 1'b0;
      chk_stall("r5_cleared", 1'b0);
      tick();
      chk("r5_rf_op1", out_operand1, 32'h1234);
      chk("r5_rf_id", 32'(out_id), 32'd3);
      chk("r5_rf_tail", 32'(tail), 32'd4);

      // Functional-unit busy and malformed unit selects
      in_r1 = 5'd0; in_fu = 2'b10; fu_stall = 2'b10;
      chk_stall("fu_busy", 1'b1);
      tick();
      chk("fu_busy_valid", 32'(out_valid), 32'd0);
      fu_stall = 2'b01;
      chk_stall("fu_other_busy", 1'b0);
      tick();
      chk("fu_valid", 32'(out_valid), 32'd1);
      chk("fu_out", 32'(out_fu), 32'd2);
      chk("fu_id", 32'(out_id), 32'd4);
      fu_stall = 2'b00;
      in_fu = 2'b11;
      chk_stall("fu_two_hot", 1'b1);
      in_fu = 2'b00;
      chk_stall("fu_zero", 1'b1);
      in_fu = 2'b01; rob_stall = 1'b1;
      chk_stall("rob_full", 1'b1);
      in_valid = 1'b0;
      chk_stall("no_valid", 1'b0);
      rob_stall = 1'b0; in_valid = 1'b1;

      // r7 pending: blocks register operand2 but not the immediate form
      in_dest = 5'd7; in_we = 1'b1;
      tick();
      chk("prod7_id", 32'(out_id), 32'd5);
      in_we = 1'b0; in_dest = 5'd0; in_r2 = 5'd7; in_ie = 1'b0;
      chk_stall("r2_hazard", 1'b1);
      in_ie = 1'b1; in_immediate = 32'hAB;
      chk_stall("r2_imm_no_hazard", 1'b0);
      tick();
      chk("imm_op2", out_operand2, 32'hAB);
      chk("imm_id", 32'(out_id), 32'd6);

      // Write to r0 dispatches but never makes r0 pending; tail wraps 7 -> 0
      in_dest = 5'd0; in_we = 1'b1;
      tick();
      chk("r0_id", 32'(out_id), 32'd7);
      chk("wrap_tail", 32'(tail), 32'd0);
      in_we = 1'b0; in_r1 = 5'd0; in_r2 = 5'd0; in_ie = 1'b0;
      rf_data1 = 32'h11; rf_data2 = 32'h22;
      chk_stall("r0_no_hazard", 1'b0);
      tick();
      chk("r0_op1", out_operand1, 32'h11);
      chk("r0_op2", out_operand2, 32'h22);
      chk("r0_read_id", 32'(out_id), 32'd0);

      // Flush clears scoreboard and restores tail, blocking the present instruction
      in_dest = 5'd5; in_we = 1'b1;
      tick();
      chk("prod5b_id", 32'(out_id), 32'd1);
      in_dest = 5'd0; in_we = 1'b0; flush = 1'b1; flush_tail = 3'd4;
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_tail", 32'(tail), 32'd4);
      flush = 1'b0; in_r1 = 5'd7; in_r2 = 5'd5; rf_data1 = 32'h70; rf_data2 = 32'h99;
      chk_stall("post_flush_stall", 1'b0);
      tick();
      chk("post_flush_op1", out_operand1, 32'h70);
      chk("post_flush_op2", out_operand2, 32'h99);
      chk("post_flush_id", 32'(out_id), 32'd4);

      // Eight back-to-back dispatches from tail 0
      in_valid = 1'b0; flush = 1'b1; flush_tail = 3'd0;
      tick();
      chk("b2b_start_tail", 32'(tail), 32'd0);
      flush = 1'b0; in_valid = 1'b1; in_r1 = 5'd0; in_r2 = 5'd0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("b2b_valid", 32'(out_valid), 32'd1);
         chk("b2b_id", 32'(out_id), 32'(k));
      end
      chk("b2b_wrap_tail", 32'(tail), 32'd0);

      // Same-edge set of r6 by a new producer wins over writeback of the old one
      in_dest = 5'd6; in_we = 1'b1;
      tick();
      chk("prod6a_id", 32'(out_id), 32'd0);
      wb_valid = 1'b1; wb_id = 3'd0; wb_value = 32'h0;
      chk_stall("prod6b_stall", 1'b0);
      tick();
      chk("prod6b_id", 32'(out_id), 32'd1);
      wb_valid = 1'b0; in_we = 1'b0; in_dest = 5'd0; in_r1 = 5'd6;
      chk_stall("r6_still_pending", 1'b1);
      wb_valid = 1'b1; wb_id = 3'd0;
      chk_stall("r6_old_wb", 1'b1);
      wb_id = 3'd1; wb_value = 32'h66;
      chk_stall("r6_new_wb", 1'b0);
      tick();
      chk("r6_bypass_op1", out_operand1, 32'h66);
      chk("r6_bypass_id", 32'(out_id), 32'd2);

      // Asynchronous reset mid-stream, then ID numbering restarts at 0
      wb_valid = 1'b0; in_r1 = 5'd0; rf_data1 = 32'h5A; in_fu = 2'b10;
      tick();
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      chk("pre_reset_id", 32'(out_id), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk_zero_outputs("async_reset");
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("after_reset_valid", 32'(out_valid), 32'd1);
      chk("after_reset_id", 32'(out_id), 32'd0);
      chk("after_reset_tail", 32'(tail), 32'd1);
      chk("after_reset_op1", out_operand1, 32'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
